booth_mul_arbiter: RTL and testbench
====================================

Name: booth_mul_arbiter

Overview:
- Shares one `boothsalgo` Booth multiplier among NUM_REQ requesters.
- Arbitrates round-robin and latches the winner's operands.
- Sequences the multiplier's start/done handshake, with a timeout guard.
- Returns the product and the add/sub op counts on a single tagged response channel.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 32, operand width; product is 2*DATA_W
CNT_W, 5, width of multiplier add/sub op counts
TIMEOUT, 64, max cycles in WAIT before the op is aborted with an error

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  one-hot accept pulse
req_mcand  in  NUM_REQ*DATA_W  packed signed multiplicands; requester i uses slice i
req_mplier  in  NUM_REQ*DATA_W  packed signed multipliers
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  $clog2(NUM_REQ)  index of the requester being answered
rsp_product  out  2*DATA_W  signed product
rsp_add_count  out  CNT_W  multiplier addition count
rsp_sub_count  out  CNT_W  multiplier subtraction count
rsp_error  out  1  op timed out
mul_mcand  out  DATA_W  to multiplier mcand
mul_mplier  out  DATA_W  to multiplier mplier
mul_start  out  1  to multiplier signal_in
mul_product  in  2*DATA_W  from multiplier product
mul_done  in  1  from multiplier done_signal; high when idle/finished
mul_add_count  in  CNT_W  from multiplier addOP
mul_sub_count  in  CNT_W  from multiplier subOP

Behaviour:
- Reset:
  - state=IDLE, priority pointer=0, wait counter=0.
  - All outputs 0.
  - Reset mid-operation abandons the op: no response, mul_start low next cycle.
- Clock and reset: single clock `clock`; reset `reset` is synchronous, active-high.
- Requester rule: req_valid is held with stable operands until req_ready.
- FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Grants only when mul_done=1 and some req_valid=1.
  - Winner is the first asserted index at or above the pointer, wrapping.
  - req_ready[winner]=1 for exactly this cycle; operands are registered into mul_mcand/mul_mplier.
  - Next state ISSUE.
  - If mul_done=0 (multiplier still busy, e.g. after reset), no grant.
- ISSUE:
  - mul_start=1 for exactly one cycle.
  - Wait counter cleared; next state WAIT.
- WAIT:
  - mul_start=0; mul_mcand/mul_mplier held stable.
  - mul_done is ignored in the first WAIT cycle, so a stale done is never captured.
  - From the second cycle, mul_done=1 captures mul_product/add/sub counts into rsp_*, rsp_error=0, next state RESP.
  - If the counter reaches TIMEOUT first: rsp_product=0, counts=0, rsp_error=1, next state RESP.
- RESP:
  - rsp_valid=1 and rsp_id=winner.
  - All rsp_* are held stable until rsp_ready=1.
  - On handshake: pointer = winner+1 (mod NUM_REQ), next state IDLE.
  - The next grant is no earlier than the following cycle.
- Throughput: minimum 4 cycles/op plus multiplier latency; one op in flight.
- Arithmetic: the arbiter performs none; values are two's complement, passed through unchanged.
- Late mul_done after a timeout is harmless: IDLE waits for mul_done=1 before granting.
- A requester dropping req_valid while not granted is ignored (protocol violation, no state effect).

Optional Feature:
- Macro: BOOTH_ARB_BYPASS_EN.
- When defined, IDLE checks the winner's operands for a trivial case:
  - mcand=0 or mplier=0: product 0.
  - mplier=1: product = sign-extended mcand.
  - mplier=-1: product = negated sign-extended mcand.
- A trivial op goes straight to RESP with counts=0 and rsp_error=0; mul_start is never pulsed.
- The trivial check is still gated by IDLE's mul_done=1 grant condition.
- When undefined, every op goes through the multiplier.

Decomposition:
- Package booth_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - default width constants;
  - the ID_W function ($clog2(NUM_REQ)).
- One sub-module, rr_arbiter: combinational round-robin pick from req_valid and pointer, giving a one-hot grant and an index.

Test Plan:
- Single request on port 0, 113 x 4 -> exactly one req_ready[0] pulse, one mul_start pulse; rsp_product=452, rsp_id=0, rsp_error=0.
- All four valid, operands -500 x -10 on each -> responses in id order 0,1,2,3, each product 5000; pointer wraps to 0.
- rsp_ready held low 5 cycles during RESP -> rsp_* stable, no req_ready, no mul_start until the handshake.
- Multiplier stub holds mul_done=0 -> rsp_error=1, product=0 exactly TIMEOUT cycles into WAIT; next grant only after stub raises mul_done.
- Reset asserted in WAIT -> next cycle all outputs 0, no response ever issued for that op.
- BOOTH_ARB_BYPASS_EN defined, 20000 x -1 -> rsp_product=-20000, counts 0, mul_start never asserted; undefined, same op goes through the multiplier.

Source files
------------

// File: rtl/booth_arb_pkg.sv
// Shared types and constants for the Booth multiplier arbiter slice.
package booth_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_CNT_W   = 5;
  localparam int unsigned DEF_TIMEOUT = 64;

  // Requester index width; never below one bit.
  function automatic int unsigned ID_W(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above the pointer, wrapping.
module rr_arbiter
  import booth_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [ID_W(NUM_REQ)-1:0] i_ptr,
  output logic [NUM_REQ-1:0]       o_grant,
  output logic [ID_W(NUM_REQ)-1:0] o_idx,
  output logic                     o_any
);

  localparam int unsigned IW = ID_W(NUM_REQ);

  logic [IW-1:0] w_j;
  int unsigned   w_sum;
  logic          w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = 0;
    w_j     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = (32'(i_ptr) + 32'(i)) % NUM_REQ;
      w_j   = IW'(w_sum);
      if (!w_found && i_req[w_j]) begin
        w_found    = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Shares one Booth multiplier among NUM_REQ requesters with round-robin arbitration.
// Optional trivial-operand bypass (x0, x1, x-1) enabled by defining BOOTH_ARB_BYPASS_EN.
module booth_mul_arbiter
  import booth_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_mcand,
  input  logic [NUM_REQ*DATA_W-1:0] req_mplier,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W(NUM_REQ)-1:0]  rsp_id,
  output logic [2*DATA_W-1:0]       rsp_product,
  output logic [CNT_W-1:0]          rsp_add_count,
  output logic [CNT_W-1:0]          rsp_sub_count,
  output logic                      rsp_error,
  output logic [DATA_W-1:0]         mul_mcand,
  output logic [DATA_W-1:0]         mul_mplier,
  output logic                      mul_start,
  input  logic [2*DATA_W-1:0]       mul_product,
  input  logic                      mul_done,
  input  logic [CNT_W-1:0]          mul_add_count,
  input  logic [CNT_W-1:0]          mul_sub_count
);

  localparam int unsigned IW = ID_W(NUM_REQ);
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam int unsigned PW = 2 * DATA_W;

  state_e             r_state;
  state_e             w_next;
  logic [IW-1:0]      r_ptr;
  logic [IW-1:0]      r_win_id;
  logic [TW-1:0]      r_wait_cnt;
  logic [DATA_W-1:0]  r_mcand;
  logic [DATA_W-1:0]  r_mplier;
  logic [PW-1:0]      r_product;
  logic [CNT_W-1:0]   r_add;
  logic [CNT_W-1:0]   r_sub;
  logic               r_error;

  logic [NUM_REQ-1:0] w_grant;
  logic [IW-1:0]      w_idx;
  logic               w_any;
  logic               w_grant_en;
  logic               w_done_take;
  logic               w_timeout;
  logic               w_trivial;
  logic [DATA_W-1:0]  w_win_mcand;
  logic [DATA_W-1:0]  w_win_mplier;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .i_req  (req_valid),
    .i_ptr  (r_ptr),
    .o_grant(w_grant),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign w_win_mcand  = req_mcand[w_idx*DATA_W +: DATA_W];
  assign w_win_mplier = req_mplier[w_idx*DATA_W +: DATA_W];

  // A busy multiplier (mul_done low) blocks new grants, covering late completions after a timeout.
  assign w_grant_en  = !reset && (r_state == IDLE) && mul_done && w_any;
  // The first WAIT cycle (counter 0) ignores a done level left over from the previous op.
  assign w_done_take = (r_state == WAIT) && (r_wait_cnt != '0) && mul_done;
  assign w_timeout   = (r_state == WAIT) && (r_wait_cnt == TW'(TIMEOUT - 1));

`ifdef BOOTH_ARB_BYPASS_EN
  logic [PW-1:0] w_mc_ext;
  logic [PW-1:0] w_triv_product;

  assign w_mc_ext = {{DATA_W{w_win_mcand[DATA_W-1]}}, w_win_mcand};

  always_comb begin
    w_trivial      = 1'b0;
    w_triv_product = '0;
    if ((w_win_mcand == '0) || (w_win_mplier == '0)) begin
      w_trivial = 1'b1;
    end else if (w_win_mplier == DATA_W'(1)) begin
      w_trivial      = 1'b1;
      w_triv_product = w_mc_ext;
    end else if (w_win_mplier == '1) begin
      w_trivial      = 1'b1;
      w_triv_product = -w_mc_ext;
    end
  end
`else
  assign w_trivial = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_grant_en) w_next = w_trivial ? RESP : ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (w_done_take || w_timeout) w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    req_ready = '0;
    mul_start = 1'b0;
    rsp_valid = 1'b0;
    if (w_grant_en) req_ready = w_grant;
    if (r_state == ISSUE) mul_start = 1'b1;
    if (r_state == RESP)  rsp_valid = 1'b1;
  end

  // Operand latch, wait counter, response capture and pointer advance.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr      <= '0;
      r_win_id   <= '0;
      r_wait_cnt <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_product  <= '0;
      r_add      <= '0;
      r_sub      <= '0;
      r_error    <= 1'b0;
    end else begin
      if (w_grant_en) begin
        r_win_id <= w_idx;
        r_mcand  <= w_win_mcand;
        r_mplier <= w_win_mplier;
`ifdef BOOTH_ARB_BYPASS_EN
        if (w_trivial) begin
          r_product <= w_triv_product;
          r_add     <= '0;
          r_sub     <= '0;
          r_error   <= 1'b0;
        end
`endif
      end

      if (r_state == ISSUE)     r_wait_cnt <= '0;
      else if (r_state == WAIT) r_wait_cnt <= r_wait_cnt + TW'(1);

      if (w_done_take) begin
        r_product <= mul_product;
        r_add     <= mul_add_count;
        r_sub     <= mul_sub_count;
        r_error   <= 1'b0;
      end else if (w_timeout) begin
        r_product <= '0;
        r_add     <= '0;
        r_sub     <= '0;
        r_error   <= 1'b1;
      end

      if ((r_state == RESP) && rsp_ready)
        r_ptr <= (r_win_id == IW'(NUM_REQ - 1)) ? '0 : r_win_id + IW'(1);
    end
  end

  assign rsp_id        = r_win_id;
  assign rsp_product   = r_product;
  assign rsp_add_count = r_add;
  assign rsp_sub_count = r_sub;
  assign rsp_error     = r_error;
  assign mul_mcand     = r_mcand;
  assign mul_mplier    = r_mplier;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter with a behavioural multiplier stub.
// Expectations for the trivial-operand op follow BOOTH_ARB_BYPASS_EN.
module tb_booth_mul_arbiter;

  localparam int NR   = 4;
  localparam int DW   = 32;
  localparam int CW   = 5;
  localparam int TOUT = 64;
  localparam int LAT  = 6;

`ifdef BOOTH_ARB_BYPASS_EN
  localparam int BYP_STARTS = 0;
  localparam int BYP_ADD    = 0;
  localparam int BYP_SUB    = 0;
`else
  localparam int BYP_STARTS = 1;
  localparam int BYP_ADD    = 7;
  localparam int BYP_SUB    = 4;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_mcand = '0;
  logic [NR*DW-1:0]  req_mplier = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [1:0]        rsp_id;
  logic [2*DW-1:0]   rsp_product;
  logic [CW-1:0]     rsp_add_count;
  logic [CW-1:0]     rsp_sub_count;
  logic              rsp_error;
  logic [DW-1:0]     mul_mcand;
  logic [DW-1:0]     mul_mplier;
  logic              mul_start;
  logic [2*DW-1:0]   mul_product = '0;
  logic              mul_done = 1'b1;
  logic [CW-1:0]     mul_add_count = '0;
  logic [CW-1:0]     mul_sub_count = '0;

  logic stub_hang = 1'b0;
  int   stub_cnt = 0;
  int   n_start = 0;
  int   n_rsp = 0;
  int   n_ready [NR] = '{default: 0};
  logic rsp_valid_q = 1'b0;

  int n_err = 0;
  int n_checks = 0;

  booth_mul_arbiter dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mcand(req_mcand), .req_mplier(req_mplier),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_product(rsp_product), .rsp_add_count(rsp_add_count),
    .rsp_sub_count(rsp_sub_count), .rsp_error(rsp_error),
    .mul_mcand(mul_mcand), .mul_mplier(mul_mplier), .mul_start(mul_start),
    .mul_product(mul_product), .mul_done(mul_done),
    .mul_add_count(mul_add_count), .mul_sub_count(mul_sub_count)
  );

  always #5 clock = ~clock;

  // Multiplier stub: done drops on start, returns LAT cycles later unless hung.
  always @(posedge clock) begin
    if (mul_start) begin
      mul_done <= 1'b0;
      stub_cnt <= LAT;
    end else if (!mul_done && !stub_hang) begin
      if (stub_cnt == 0) begin
        mul_done      <= 1'b1;
        mul_product   <= {{DW{mul_mcand[DW-1]}}, mul_mcand} * {{DW{mul_mplier[DW-1]}}, mul_mplier};
        mul_add_count <= CW'(7);
        mul_sub_count <= CW'(4);
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  // Event counters sampled on the active edge.
  always @(posedge clock) begin
    if (mul_start) n_start <= n_start + 1;
    for (int i = 0; i < NR; i++)
      if (req_ready[i]) n_ready[i] <= n_ready[i] + 1;
    if (rsp_valid && !rsp_valid_q) n_rsp <= n_rsp + 1;
    rsp_valid_q <= rsp_valid;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int id, input int mc, input int mp);
    req_mcand[id*DW +: DW]  = DW'(mc);
    req_mplier[id*DW +: DW] = DW'(mp);
    req_valid[id]           = 1'b1;
  endtask

  // Waits for a grant, then drops that requester's valid after the accepting edge.
  task automatic wait_grant(input string tag, output int gid);
    bit got;
    got = 1'b0;
    gid = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      #1;
      if (req_ready != '0) begin
        got = 1'b1;
        for (int i = 0; i < NR; i++) if (req_ready[i]) gid = i;
      end else begin
        @(negedge clock);
      end
    end
    check({tag, "_grant_seen"}, 64'(got), 64'd1);
    @(negedge clock);
    if (got) req_valid[gid] = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      if (rsp_valid) got = 1'b1;
      else @(negedge clock);
    end
    check({tag, "_rsp_seen"}, 64'(got), 64'd1);
  endtask

  task automatic serve_one(input string tag, output int gid);
    wait_grant(tag, gid);
    wait_rsp(tag);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_mul_start"}, 64'(mul_start), 64'd0);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_mcand"},     64'(mul_mcand), 64'd0);
    check({tag, "_mplier"},    64'(mul_mplier), 64'd0);
    check({tag, "_product"},   rsp_product, 64'd0);
    check({tag, "_id"},        64'(rsp_id), 64'd0);
    check({tag, "_error"},     64'(rsp_error), 64'd0);
    check({tag, "_counts"},    64'({rsp_add_count, rsp_sub_count}), 64'd0);
  endtask

  initial begin
    int gid;
    int bs, br, b0, b1, b2, b3, bv;
    int k;
    bit got;
    logic [63:0] p_snap;
    logic [1:0]  id_snap;

    // Reset state
    repeat (2) @(negedge clock);
    check_quiet("reset");
    reset = 1'b0;
    @(negedge clock);

    // Single request 113 x 4 on port 0
    bs = n_start; b0 = n_ready[0]; b1 = n_ready[1]; b2 = n_ready[2]; b3 = n_ready[3];
    set_req(0, 113, 4);
    serve_one("t1", gid);
    check("t1_gid", 64'(gid), 64'd0);
    check("t1_product", rsp_product, 64'd452);
    check("t1_id", 64'(rsp_id), 64'd0);
    check("t1_error", 64'(rsp_error), 64'd0);
    check("t1_add", 64'(rsp_add_count), 64'd7);
    check("t1_sub", 64'(rsp_sub_count), 64'd4);
    handshake();
    check("t1_ready0_pulses", 64'(n_ready[0] - b0), 64'd1);
    check("t1_other_ready", 64'((n_ready[1] - b1) + (n_ready[2] - b2) + (n_ready[3] - b3)), 64'd0);
    check("t1_start_pulses", 64'(n_start - bs), 64'd1);

    // Reset returns the pointer to 0
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // All four valid, -500 x -10: served in id order 0..3
    for (int i = 0; i < NR; i++) set_req(i, -500, -10);
    for (int i = 0; i < NR; i++) begin
      serve_one("t2", gid);
      check("t2_gid", 64'(gid), 64'(i));
      check("t2_id", 64'(rsp_id), 64'(i));
      check("t2_product", rsp_product, 64'd5000);
      handshake();
    end

    // Pointer wrapped to 0: requester 0 beats 3
    set_req(0, 2, 3);
    set_req(3, 4, 5);
    serve_one("t2w", gid);
    check("t2w_first_id", 64'(rsp_id), 64'd0);
    check("t2w_first_product", rsp_product, 64'd6);
    handshake();
    serve_one("t2w", gid);
    check("t2w_second_id", 64'(rsp_id), 64'd3);
    check("t2w_second_product", rsp_product, 64'd20);
    handshake();

    // Backpressure: rsp_ready low for 5 cycles in RESP
    set_req(2, 7, -3);
    serve_one("t3", gid);
    set_req(1, 6, -7);
    p_snap = rsp_product; id_snap = rsp_id;
    bs = n_start; br = n_ready[1];
    check("t3_product", p_snap, 64'hFFFF_FFFF_FFFF_FFEB);
    check("t3_id", 64'(id_snap), 64'd2);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check("t3_hold_valid", 64'(rsp_valid), 64'd1);
      check("t3_hold_product", rsp_product, p_snap);
      check("t3_hold_id", 64'(rsp_id), 64'(id_snap));
    end
    check("t3_no_ready", 64'(n_ready[1] - br), 64'd0);
    check("t3_no_start", 64'(n_start - bs), 64'd0);
    handshake();
    serve_one("t3b", gid);
    check("t3b_id", 64'(rsp_id), 64'd1);
    check("t3b_product", rsp_product, 64'hFFFF_FFFF_FFFF_FFD6);
    handshake();

    // Timeout: stub never completes
    stub_hang = 1'b1;
    set_req(0, 3, 3);
    wait_grant("t4", gid);
    check("t4_start", 64'(mul_start), 64'd1);
    k = 0; got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clock);
      k++;
      if (rsp_valid) got = 1'b1;
    end
    check("t4_latency", 64'(k), 64'(TOUT + 1));
    check("t4_error", 64'(rsp_error), 64'd1);
    check("t4_product", rsp_product, 64'd0);
    check("t4_counts", 64'({rsp_add_count, rsp_sub_count}), 64'd0);
    set_req(1, 2, 2);
    handshake();
    br = n_ready[1];
    repeat (8) @(negedge clock);
    check("t4_no_grant_busy", 64'(n_ready[1] - br), 64'd0);
    stub_hang = 1'b0;
    serve_one("t4b", gid);
    check("t4b_id", 64'(rsp_id), 64'd1);
    check("t4b_product", rsp_product, 64'd4);
    check("t4b_error", 64'(rsp_error), 64'd0);
    handshake();
    repeat (LAT + 4) @(negedge clock);

    // Reset asserted during WAIT abandons the op
    set_req(2, 5, 5);
    wait_grant("t5", gid);
    check("t5_start", 64'(mul_start), 64'd1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_quiet("t5_reset");
    reset = 1'b0;
    bv = n_rsp;
    repeat (30) @(negedge clock);
    check("t5_no_response", 64'(n_rsp - bv), 64'd0);

    // 20000 x -1: bypassed when the feature is enabled
    bs = n_start;
    set_req(3, 20000, -1);
    serve_one("t6", gid);
    check("t6_id", 64'(rsp_id), 64'd3);
    check("t6_product", rsp_product, 64'hFFFF_FFFF_FFFF_B1E0);
    check("t6_error", 64'(rsp_error), 64'd0);
    check("t6_add", 64'(rsp_add_count), 64'(BYP_ADD));
    check("t6_sub", 64'(rsp_sub_count), 64'(BYP_SUB));
    handshake();
    check("t6_starts", 64'(n_start - bs), 64'(BYP_STARTS));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
